mips_bus_arbiter: RTL and testbench
===================================

# mips_bus_arbiter

Two-master to one-slave arbiter for the CPU memory bus. It lets the MIPS core and a second requester (e.g. a loader or DMA engine) share the single `cpu_ram` port. Both use the same address/read/write/waitrequest/byteenable handshake. It sits between the masters and the RAM, grants one whole transfer at a time, and stalls the losing master with `waitrequest`.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width; byteenable width is DATA_WIDTH/8.
- `FIXED_PRIORITY`, 0:
  - 0: round-robin.
  - 1: m0 always wins a contested arbitration.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `m0_address` / `m1_address`  in  ADDR_WIDTH  master byte address.
- `m0_read` / `m1_read`  in  1  read request.
- `m0_write` / `m1_write`  in  1  write request.
- `m0_writedata` / `m1_writedata`  in  DATA_WIDTH  write data.
- `m0_byteenable` / `m1_byteenable`  in  DATA_WIDTH/8  byte lanes.
- `m0_waitrequest` / `m1_waitrequest`  out  1  stall to master.
- `m0_readdata` / `m1_readdata`  out  DATA_WIDTH  both equal `s_readdata`.
- `s_address`, `s_read`, `s_write`, `s_writedata`, `s_byteenable`  out  forwarded to RAM.
- `s_waitrequest`  in  1  RAM stall.
- `s_readdata`  in  DATA_WIDTH  RAM read data.
- `grant`  out  2  one-hot current owner; 00 when idle.

## Operation
- Request: `mX_req = mX_read | mX_write`.
- Transfer completes on a rising edge where the granted master has req=1 and `s_waitrequest`=0.
- States and behaviour:
  - IDLE: grant=00. s_read=s_write=0. Both mX_waitrequest=1.
  - GNT0: grant=01. m0 signals are forwarded combinationally to s_*. m0_waitrequest=s_waitrequest. m1_waitrequest=1.
  - GNT1: grant=10. Mirror of GNT0.
- IDLE transitions:
  - Only one master requesting: grant it.
  - Both requesting, FIXED_PRIORITY=1: grant m0.
  - Both requesting, round-robin: grant the master not in `last_grant`.
  - `last_grant` is updated whenever a grant is issued.
- GNTx transitions on a completing edge:
  - Other master requesting: go to GNTother (back-to-back handoff, no idle cycle).
  - Else x still requesting: stay in GNTx for its next transfer.
  - Else: go to IDLE.
  - With FIXED_PRIORITY=1, the handoff rule applies only toward m0; m1 yields only to m0.
- GNTx, granted master drops req without completing (protocol abort): go to IDLE next edge. s_read/s_write follow the master's inputs, so they are already 0.
- Granted master asserts read and write together: s_write=mX_write and s_read=0 (write wins).
- The non-granted master's inputs never reach s_*. Its request must stay held; the arbiter does not latch it.
- Reset, including mid-transfer:
  - State goes to IDLE immediately and asynchronously.
  - s_read=s_write=0, both waitrequests=1, grant=00.
  - `last_grant`=m1, so the first contested round-robin grant goes to m0.
- s_address, s_writedata, s_byteenable show the granted master's values. In IDLE they show m0's values; they are don't-care for the RAM because read/write are 0.

## Timing
- Arbitration latency: a request raised in IDLE is granted at the next edge. The master sees waitrequest=1 for at least that first cycle. With RAM_WAIT=0, a single isolated read completes on the 2nd edge after the request is asserted.
- Handoff: the other master's forwarding starts in the cycle directly after the completing edge. No bubble.
- Sustained contention, RAM_WAIT=0, round-robin: transfers alternate m0,m1,m0,… with one transfer per cycle after the first grant.
- Wait states: grant is held for the whole s_waitrequest=1 period and never changes mid-transfer.
- readdata is combinational pass-through and is valid in the completing cycle. The arbiter adds no register stage on data.
- All s_* outputs and mX_waitrequest are combinational from the state register and the inputs. There is no combinational path from mX inputs to `grant`.

## Test plan
- Single master: m0 reads 0xBFC00000, RAM returns 0x24020005, RAM_WAIT=0 → grant=01 one edge after the request. m0 sees readdata=0x24020005 with waitrequest=0 in the next cycle. m1_waitrequest stays 1 throughout. Returns to IDLE after completion.
- Contention, round-robin: both masters read from reset → order m0, m1, m0, m1 on consecutive completing edges. No idle cycle between transfers. grant toggles 01/10.
- FIXED_PRIORITY=1: m0 issues 4 back-to-back writes while m1 requests → m1 is granted only after m0 drops req. Exactly 4 RAM writes from m0 occur before any m1 transfer.
- Wait states: RAM_WAIT=3 with m1 granted mid-write and m0 requesting → grant stays 10 for all stalled cycles. s_address and s_writedata stay stable. The handoff to m0 happens on the completing edge.
- Abort and both-asserted: granted m0 drops read with s_waitrequest=1 → IDLE next edge with no RAM access. m1 asserts read=write=1 to 0x100 → RAM sees a write only.
- Reset mid-transfer: reset asserted while grant=10 and s_waitrequest=1 → s_write=0, grant=00, both waitrequests=1 within the same cycle, without waiting for a clock edge. After release, contested requests are granted to m0 first.

Source files
------------

// File: rtl/mips_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_arbiter_if
// Description : Bundle of both master ports and the shared RAM port for the
//               two-master CPU memory bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_bus_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   // master 0 (MIPS core)
   logic [ADDR_WIDTH-1:0] m0_address;
   logic                  m0_read;
   logic                  m0_write;
   logic [DATA_WIDTH-1:0] m0_writedata;
   logic [BE_WIDTH-1:0]   m0_byteenable;
   logic                  m0_waitrequest;
   logic [DATA_WIDTH-1:0] m0_readdata;

   // master 1 (loader / DMA)
   logic [ADDR_WIDTH-1:0] m1_address;
   logic                  m1_read;
   logic                  m1_write;
   logic [DATA_WIDTH-1:0] m1_writedata;
   logic [BE_WIDTH-1:0]   m1_byteenable;
   logic                  m1_waitrequest;
   logic [DATA_WIDTH-1:0] m1_readdata;

   // shared RAM port
   logic [ADDR_WIDTH-1:0] s_address;
   logic                  s_read;
   logic                  s_write;
   logic [DATA_WIDTH-1:0] s_writedata;
   logic [BE_WIDTH-1:0]   s_byteenable;
   logic                  s_waitrequest;
   logic [DATA_WIDTH-1:0] s_readdata;

   // current owner, one-hot
   logic [1:0]            grant;

   // Environment side: drives both masters' requests and the RAM responses.
   modport master (
      output m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
      output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
      output s_waitrequest, s_readdata,
      input  m0_waitrequest, m0_readdata, m1_waitrequest, m1_readdata,
      input  s_address, s_read, s_write, s_writedata, s_byteenable, grant
   );

   // Arbiter side.
   modport slave (
      input  m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
      input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
      input  s_waitrequest, s_readdata,
      output m0_waitrequest, m0_readdata, m1_waitrequest, m1_readdata,
      output s_address, s_read, s_write, s_writedata, s_byteenable, grant
   );
endinterface
`default_nettype wire

// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_arbiter
// Description : Grants the single RAM port to one of two masters for a whole
//               transfer at a time (round-robin or m0-fixed priority) and
//               stalls the loser with waitrequest.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int FIXED_PRIORITY = 0
) (
   input  wire                       clk,
   input  wire                       reset,
   mips_bus_arbiter_if.slave         bus
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam bit c_fixed  = (FIXED_PRIORITY != 0);

   // State encoding doubles as the one-hot grant pattern.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GNT0 = 2'b01,
      ST_GNT1 = 2'b10
   } state_t;

   state_t     r_state;
   logic [1:0] r_grant;
   logic       r_last_m1;   // 1: most recent grant went to m1

   logic                  w_req0;
   logic                  w_req1;
   logic                  w_sel0;
   logic                  w_sel1;
   logic [ADDR_WIDTH-1:0] w_address;
   logic [DATA_WIDTH-1:0] w_writedata;
   logic [BE_WIDTH-1:0]   w_byteenable;

   assign w_req0 = bus.m0_read | bus.m0_write;
   assign w_req1 = bus.m1_read | bus.m1_write;
   assign w_sel0 = (r_state == ST_GNT0);
   assign w_sel1 = (r_state == ST_GNT1);

   // Arbitration FSM: grant changes only on completing edges, aborts or from idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_grant   <= 2'b00;
         r_last_m1 <= 1'b1;    // first contested round-robin grant goes to m0
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req0 && (!w_req1 || c_fixed || r_last_m1)) begin
                  r_state   <= ST_GNT0;
                  r_grant   <= 2'b01;
                  r_last_m1 <= 1'b0;
               end else if (w_req1) begin
                  r_state   <= ST_GNT1;
                  r_grant   <= 2'b10;
                  r_last_m1 <= 1'b1;
               end
            end
            ST_GNT0: begin
               if (!w_req0) begin
                  // abandoned transfer: release the bus
                  r_state <= ST_IDLE;
                  r_grant <= 2'b00;
               end else if (!bus.s_waitrequest && w_req1 && !c_fixed) begin
                  // completing edge with m1 waiting: hand off without a bubble
                  r_state   <= ST_GNT1;
                  r_grant   <= 2'b10;
                  r_last_m1 <= 1'b1;
               end
               // otherwise m0 keeps the bus (stalled, or its next transfer)
            end
            ST_GNT1: begin
               if (!w_req1) begin
                  r_state <= ST_IDLE;
                  r_grant <= 2'b00;
               end else if (!bus.s_waitrequest && w_req0) begin
                  // m1 always yields to a waiting m0 at completion
                  r_state   <= ST_GNT0;
                  r_grant   <= 2'b01;
                  r_last_m1 <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= 2'b00;
            end
         endcase
      end
   end

   // Address/data path: m1 only when it owns the bus, m0's values otherwise.
   assign w_address    = w_sel1 ? bus.m1_address    : bus.m0_address;
   assign w_writedata  = w_sel1 ? bus.m1_writedata  : bus.m0_writedata;
   assign w_byteenable = w_sel1 ? bus.m1_byteenable : bus.m0_byteenable;

   assign bus.s_address    = w_address;
   assign bus.s_writedata  = w_writedata;
   assign bus.s_byteenable = w_byteenable;

   // Strobes follow the owner's inputs; write wins over a simultaneous read.
   assign bus.s_write = (w_sel0 & bus.m0_write) | (w_sel1 & bus.m1_write);
   assign bus.s_read  = (w_sel0 & bus.m0_read & ~bus.m0_write)
                      | (w_sel1 & bus.m1_read & ~bus.m1_write);

   assign bus.m0_waitrequest = w_sel0 ? bus.s_waitrequest : 1'b1;
   assign bus.m1_waitrequest = w_sel1 ? bus.s_waitrequest : 1'b1;

   assign bus.m0_readdata = bus.s_readdata;
   assign bus.m1_readdata = bus.s_readdata;

   assign bus.grant = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_bus_arbiter
// Description : Directed self-checking bench; one round-robin and one
//               fixed-priority arbiter share clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_bus_arbiter;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   mips_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) brr ();
   mips_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bfp ();

   mips_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(0)) u_rr (
      .clk   (clk),
      .reset (reset),
      .bus   (brr)
   );

   mips_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(1)) u_fp (
      .clk   (clk),
      .reset (reset),
      .bus   (bfp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance to 1 ns after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      brr.m0_address = '0; brr.m0_read = 0; brr.m0_write = 0; brr.m0_writedata = '0; brr.m0_byteenable = 4'hF;
      brr.m1_address = '0; brr.m1_read = 0; brr.m1_write = 0; brr.m1_writedata = '0; brr.m1_byteenable = 4'hF;
      brr.s_waitrequest = 0; brr.s_readdata = '0;
      bfp.m0_address = '0; bfp.m0_read = 0; bfp.m0_write = 0; bfp.m0_writedata = '0; bfp.m0_byteenable = 4'hF;
      bfp.m1_address = '0; bfp.m1_read = 0; bfp.m1_write = 0; bfp.m1_writedata = '0; bfp.m1_byteenable = 4'hF;
      bfp.s_waitrequest = 0; bfp.s_readdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      step();
      n_cmp++; if (brr.grant !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b exp 00", brr.grant); end
      n_cmp++; if (brr.s_read !== 1'b0 || brr.s_write !== 1'b0) begin n_err++; $display("FAIL reset_strobes: got r=%b w=%b exp 0/0", brr.s_read, brr.s_write); end
      n_cmp++; if (brr.m0_waitrequest !== 1'b1 || brr.m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL reset_wait: got %b%b exp 11", brr.m0_waitrequest, brr.m1_waitrequest); end
      n_cmp++; if (bfp.grant !== 2'b00) begin n_err++; $display("FAIL reset_grant_fp: got %b exp 00", bfp.grant); end
   endtask

   task automatic test_single();
      do_reset();
      brr.m0_address = 32'hBFC00000; brr.m0_read = 1; brr.s_readdata = 32'h24020005;
      #1;
      n_cmp++; if (brr.grant !== 2'b00 || brr.m0_waitrequest !== 1'b1 || brr.s_read !== 1'b0) begin n_err++; $display("FAIL single_arb_cycle: got grant=%b wait=%b rd=%b exp 00/1/0", brr.grant, brr.m0_waitrequest, brr.s_read); end
      step();
      n_cmp++; if (brr.grant !== 2'b01) begin n_err++; $display("FAIL single_grant: got %b exp 01", brr.grant); end
      n_cmp++; if (brr.s_read !== 1'b1 || brr.s_address !== 32'hBFC00000) begin n_err++; $display("FAIL single_fwd: got rd=%b addr=%h exp 1/bfc00000", brr.s_read, brr.s_address); end
      n_cmp++; if (brr.m0_waitrequest !== 1'b0 || brr.m0_readdata !== 32'h24020005) begin n_err++; $display("FAIL single_data: got wait=%b data=%h exp 0/24020005", brr.m0_waitrequest, brr.m0_readdata); end
      n_cmp++; if (brr.m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL single_m1_wait: got %b exp 1", brr.m1_waitrequest); end
      step();
      brr.m0_read = 0;
      #1;
      n_cmp++; if (brr.s_read !== 1'b0) begin n_err++; $display("FAIL single_drop_rd: got %b exp 0", brr.s_read); end
      step();
      n_cmp++; if (brr.grant !== 2'b00 || brr.m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL single_idle: got grant=%b wait=%b exp 00/1", brr.grant, brr.m0_waitrequest); end
   endtask

   task automatic test_rr_contention();
      logic [1:0]  exp_g [4];
      logic [31:0] exp_a [4];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      exp_a[0] = 32'h10; exp_a[1] = 32'h20; exp_a[2] = 32'h10; exp_a[3] = 32'h20;
      do_reset();
      brr.m0_address = 32'h10; brr.m0_read = 1;
      brr.m1_address = 32'h20; brr.m1_read = 1;
      for (int k = 0; k < 4; k++) begin
         step();
         n_cmp++; if (brr.grant !== exp_g[k] || brr.s_address !== exp_a[k]) begin n_err++; $display("FAIL rr_order[%0d]: got grant=%b addr=%h exp %b/%h", k, brr.grant, brr.s_address, exp_g[k], exp_a[k]); end
         n_cmp++; if ({brr.m1_waitrequest, brr.m0_waitrequest} !== ~exp_g[k]) begin n_err++; $display("FAIL rr_wait[%0d]: got %b%b exp %b", k, brr.m1_waitrequest, brr.m0_waitrequest, ~exp_g[k]); end
      end
      brr.m0_read = 0; brr.m1_read = 0;
      step();
      n_cmp++; if (brr.grant !== 2'b00) begin n_err++; $display("FAIL rr_idle: got %b exp 00", brr.grant); end
   endtask

   task automatic test_fixed_priority();
      int writes;
      writes = 0;
      do_reset();
      bfp.m0_address = 32'h40; bfp.m0_write = 1; bfp.m0_writedata = 32'h1000;
      bfp.m1_address = 32'h50; bfp.m1_read = 1;
      for (int k = 0; k < 4; k++) begin
         step();
         n_cmp++; if (bfp.grant !== 2'b01 || bfp.m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL fp_hold[%0d]: got grant=%b m1wait=%b exp 01/1", k, bfp.grant, bfp.m1_waitrequest); end
         n_cmp++; if (bfp.s_writedata !== 32'h1000 + k) begin n_err++; $display("FAIL fp_wdata[%0d]: got %h exp %h", k, bfp.s_writedata, 32'h1000 + k); end
         if (bfp.s_write === 1'b1 && bfp.grant === 2'b01) writes++;
         bfp.m0_writedata = 32'h1000 + k + 1;
      end
      n_cmp++; if (writes != 4) begin n_err++; $display("FAIL fp_write_count: got %0d exp 4", writes); end
      step();
      bfp.m0_write = 0;
      #1;
      n_cmp++; if (bfp.grant !== 2'b01 || bfp.s_write !== 1'b0 || bfp.m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL fp_m0_kept: got grant=%b wr=%b m1wait=%b exp 01/0/1", bfp.grant, bfp.s_write, bfp.m1_waitrequest); end
      step();
      n_cmp++; if (bfp.grant !== 2'b00) begin n_err++; $display("FAIL fp_idle: got %b exp 00", bfp.grant); end
      step();
      n_cmp++; if (bfp.grant !== 2'b10 || bfp.s_read !== 1'b1 || bfp.s_address !== 32'h50) begin n_err++; $display("FAIL fp_m1_grant: got grant=%b rd=%b addr=%h exp 10/1/50", bfp.grant, bfp.s_read, bfp.s_address); end
      bfp.m1_read = 0;
      step();
      n_cmp++; if (bfp.grant !== 2'b00) begin n_err++; $display("FAIL fp_end_idle: got %b exp 00", bfp.grant); end
   endtask

   task automatic test_wait_states();
      do_reset();
      brr.m1_address = 32'h44; brr.m1_write = 1; brr.m1_writedata = 32'hDEADBEEF; brr.s_waitrequest = 1;
      step();
      brr.m0_address = 32'h80; brr.m0_read = 1;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (brr.grant !== 2'b10 || brr.m1_waitrequest !== 1'b1 || brr.m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL ws_hold[%0d]: got grant=%b wait=%b%b exp 10/11", k, brr.grant, brr.m1_waitrequest, brr.m0_waitrequest); end
         n_cmp++; if (brr.s_address !== 32'h44 || brr.s_writedata !== 32'hDEADBEEF || brr.s_write !== 1'b1) begin n_err++; $display("FAIL ws_stable[%0d]: got addr=%h wd=%h wr=%b exp 44/deadbeef/1", k, brr.s_address, brr.s_writedata, brr.s_write); end
         step();
      end
      brr.s_waitrequest = 0;
      #1;
      n_cmp++; if (brr.grant !== 2'b10 || brr.m1_waitrequest !== 1'b0) begin n_err++; $display("FAIL ws_complete: got grant=%b m1wait=%b exp 10/0", brr.grant, brr.m1_waitrequest); end
      step();
      brr.m1_write = 0;
      #1;
      n_cmp++; if (brr.grant !== 2'b01 || brr.s_read !== 1'b1 || brr.s_write !== 1'b0 || brr.s_address !== 32'h80) begin n_err++; $display("FAIL ws_handoff: got grant=%b rd=%b wr=%b addr=%h exp 01/1/0/80", brr.grant, brr.s_read, brr.s_write, brr.s_address); end
      brr.m0_read = 0;
      step();
      n_cmp++; if (brr.grant !== 2'b00) begin n_err++; $display("FAIL ws_idle: got %b exp 00", brr.grant); end
   endtask

   task automatic test_abort_both();
      do_reset();
      brr.m0_address = 32'h300; brr.m0_read = 1; brr.s_waitrequest = 1;
      step();
      n_cmp++; if (brr.grant !== 2'b01 || brr.s_read !== 1'b1) begin n_err++; $display("FAIL abort_grant: got grant=%b rd=%b exp 01/1", brr.grant, brr.s_read); end
      brr.m0_read = 0;
      #1;
      n_cmp++; if (brr.s_read !== 1'b0 || brr.s_write !== 1'b0) begin n_err++; $display("FAIL abort_no_access: got rd=%b wr=%b exp 0/0", brr.s_read, brr.s_write); end
      step();
      n_cmp++; if (brr.grant !== 2'b00) begin n_err++; $display("FAIL abort_idle: got %b exp 00", brr.grant); end
      brr.s_waitrequest = 0;
      brr.m1_address = 32'h100; brr.m1_read = 1; brr.m1_write = 1; brr.m1_writedata = 32'hA5A5A5A5;
      step();
      n_cmp++; if (brr.grant !== 2'b10 || brr.s_write !== 1'b1 || brr.s_read !== 1'b0) begin n_err++; $display("FAIL both_write_wins: got grant=%b wr=%b rd=%b exp 10/1/0", brr.grant, brr.s_write, brr.s_read); end
      n_cmp++; if (brr.s_address !== 32'h100 || brr.s_writedata !== 32'hA5A5A5A5) begin n_err++; $display("FAIL both_fwd: got addr=%h wd=%h exp 100/a5a5a5a5", brr.s_address, brr.s_writedata); end
      step();
      brr.m1_read = 0; brr.m1_write = 0;
      step();
      n_cmp++; if (brr.grant !== 2'b00) begin n_err++; $display("FAIL both_idle: got %b exp 00", brr.grant); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      brr.m1_address = 32'h200; brr.m1_write = 1; brr.s_waitrequest = 1;
      step();
      n_cmp++; if (brr.grant !== 2'b10 || brr.s_write !== 1'b1) begin n_err++; $display("FAIL rmid_pre: got grant=%b wr=%b exp 10/1", brr.grant, brr.s_write); end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++; if (brr.s_write !== 1'b0 || brr.grant !== 2'b00) begin n_err++; $display("FAIL rmid_async: got wr=%b grant=%b exp 0/00", brr.s_write, brr.grant); end
      n_cmp++; if (brr.m0_waitrequest !== 1'b1 || brr.m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL rmid_wait: got %b%b exp 11", brr.m0_waitrequest, brr.m1_waitrequest); end
      #2;
      reset = 1'b0;
      brr.m1_write = 0; brr.s_waitrequest = 0;
      brr.m0_read = 1; brr.m1_read = 1;
      step();
      n_cmp++; if (brr.grant !== 2'b01) begin n_err++; $display("FAIL rmid_first_m0: got %b exp 01", brr.grant); end
      brr.m0_read = 0; brr.m1_read = 0;
      step();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_single();
      test_rr_contention();
      test_fixed_priority();
      test_wait_states();
      test_abort_both();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
